// File: rtl/signed_divider_seq_pkg.sv
// Shared definitions for the sequential multiplier/divider family:
// FSM state encoding and iteration-counter sizing.
package signed_divider_seq_pkg;

  localparam int STATE_W = 2;
  // Wide enough to hold an iteration count of 64 (largest legal WIDTH).
  localparam int CNT_W   = 7;

  localparam logic [STATE_W-1:0] ENC_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ENC_ITER = 2'd1;
  localparam logic [STATE_W-1:0] ENC_FIX  = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = ENC_IDLE,
    ITER = ENC_ITER,
    FIX  = ENC_FIX
  } state_e;

endpackage

// File: rtl/signed_divider_seq_div_restoring_step.sv
// One unsigned restoring radix-2 division step, purely combinational.
// The partial remainder is WIDTH+1 bits; the bit shifted out of its top is
// kept as an extra magnitude bit so the compare never loses information.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic             shifted_hi;
  logic [WIDTH+1:0] diff;

  // Shift in the next dividend bit, trial-subtract, keep the difference when it fits.
  always_comb begin
    shifted    = {rem_i[WIDTH-1:0], dvd_bit_i};
    shifted_hi = rem_i[WIDTH];
    diff       = {1'b0, shifted} - {2'b00, dvs_i};
    if (shifted_hi || !diff[WIDTH+1]) begin
      rem_o   = diff[WIDTH:0];
      q_bit_o = 1'b1;
    end else begin
      rem_o   = shifted;
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/signed_divider_seq.sv
// Sequential signed divider: magnitudes are divided with one restoring step
// per clock, then the quotient/remainder signs are fixed up.
// Quotient truncates toward zero; remainder takes the dividend's sign.
// Handshake: operands are taken on a rising edge where operands_valid and
// ready are both high; ready is high only in IDLE and nothing is queued.
// result_valid pulses for one cycle when quotient/remainder update.
module signed_divider_seq
  import signed_divider_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic                    operands_valid,
  output logic                    ready,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    result_valid,
  output logic                    div_by_zero,
  output state_e                  dbg_state_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;      // |A|, shifted left as bits are consumed
  logic [WIDTH-1:0] dvs_q;      // |B|
  logic [WIDTH:0]   rem_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // quotient bits, MSB first
  logic             sign_a_q;
  logic             sign_q_q;
  logic             dz_q;
  logic             fix_pub_q;  // second FIX cycle: publish results

  logic [WIDTH-1:0] a_u;
  logic [WIDTH-1:0] b_u;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_d;
  logic             q_bit_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_u   = A;
    b_u   = B;
    a_mag = a_u[WIDTH-1] ? (~a_u + 1'b1) : a_u;
    b_mag = b_u[WIDTH-1] ? (~b_u + 1'b1) : b_u;
  end

  // Sign correction of the magnitude results, natural WIDTH-bit wrap.
  always_comb begin
    quo_fix = sign_q_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = sign_a_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
  end

  div_restoring_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit_d)
  );

  assign ready       = (state_q == IDLE);
  assign dbg_state_o = state_q;

  // Control FSM and datapath: accept, WIDTH restoring steps, two-cycle fix-up
  // (sign correction in place, then publish with the result_valid pulse).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      sign_a_q     <= 1'b0;
      sign_q_q     <= 1'b0;
      dz_q         <= 1'b0;
      fix_pub_q    <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (operands_valid) begin
            dvd_q     <= a_mag;
            dvs_q     <= b_mag;
            sign_a_q  <= A[WIDTH-1];
            sign_q_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            dz_q      <= (B == '0);
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= CNT_W'(WIDTH);
            fix_pub_q <= 1'b0;
            state_q   <= ITER;
          end
        end
        ITER: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[WIDTH-2:0], q_bit_d};
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (!fix_pub_q) begin
            // A zero divisor yields all-ones quotient; remainder restores A.
            quo_q     <= dz_q ? '1 : quo_fix;
            rem_q     <= {1'b0, rem_fix};
            fix_pub_q <= 1'b1;
          end else begin
            quotient     <= quo_q;
            remainder    <= rem_q[WIDTH-1:0];
            div_by_zero  <= dz_q;
            result_valid <= 1'b1;
            fix_pub_q    <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Self-checking bench for signed_divider_seq at WIDTH = 32.
module tb_signed_divider_seq;
  import signed_divider_seq_pkg::*;

  localparam int W       = 32;
  localparam int LAT     = W + 2;
  localparam int MAX_WAIT = 200;

  logic                clk;
  logic                reset;
  logic signed [W-1:0] A;
  logic signed [W-1:0] B;
  logic                operands_valid;
  logic                ready;
  logic signed [W-1:0] quotient;
  logic signed [W-1:0] remainder;
  logic                result_valid;
  logic                div_by_zero;
  state_e              dbg_state_o;

  int total;
  int bad;

  signed_divider_seq #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .A              (A),
    .B              (B),
    .operands_valid (operands_valid),
    .ready          (ready),
    .quotient       (quotient),
    .remainder      (remainder),
    .result_valid   (result_valid),
    .div_by_zero    (div_by_zero),
    .dbg_state_o    (dbg_state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division on 64-bit values, truncated to W bits.
  function automatic void ref_div(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint la;
    longint lb;
    la = a;
    lb = b;
    if (lb == 0) begin
      q = '1;
      r = a;
      dz = 1'b1;
    end else begin
      q = W'(la / lb);
      r = W'(la % lb);
      dz = 1'b0;
    end
  endfunction

  // Driver: wait for ready, present one operand pair, return the result and
  // the number of rising edges from the accepting edge to result_valid.
  task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    A = a;
    B = b;
    operands_valid = 1'b1;
    @(posedge clk);
    #1 operands_valid = 1'b0;
    lat = -1;
    for (int e = 1; e <= MAX_WAIT; e++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        lat = e;
        break;
      end
    end
    q = quotient;
    r = remainder;
    dz = div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    A = '0;
    B = '0;
    operands_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (quotient !== '0) begin bad++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    total++; if (remainder !== '0) begin bad++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_div_by_zero got=%b exp=0", div_by_zero); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (dbg_state_o !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=IDLE", dbg_state_o); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic signed [W-1:0] ta [7];
    logic signed [W-1:0] tb [7];
    logic [W-1:0]        tq [7];
    logic [W-1:0]        tr [7];
    logic                tdz [7];
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    int lat;
    ta[0] = 100;          tb[0] = 7;  tq[0] = 32'd14;       tr[0] = 32'd2;       tdz[0] = 1'b0;
    ta[1] = -100;         tb[1] = 7;  tq[1] = -32'sd14;     tr[1] = -32'sd2;     tdz[1] = 1'b0;
    ta[2] = 100;          tb[2] = -7; tq[2] = -32'sd14;     tr[2] = 32'd2;       tdz[2] = 1'b0;
    ta[3] = 7;            tb[3] = 0;  tq[3] = 32'hFFFFFFFF; tr[3] = 32'd7;       tdz[3] = 1'b1;
    ta[4] = 9;            tb[4] = 3;  tq[4] = 32'd3;        tr[4] = 32'd0;       tdz[4] = 1'b0;
    ta[5] = 32'h80000000; tb[5] = -1; tq[5] = 32'h80000000; tr[5] = 32'd0;       tdz[5] = 1'b0;
    ta[6] = 32'h80000000; tb[6] = 1;  tq[6] = 32'h80000000; tr[6] = 32'd0;       tdz[6] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], q, r, dz, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      total++; if (q !== tq[i]) begin bad++; $display("FAIL dir%0d_quotient got=%h exp=%h", i, q, tq[i]); end
      total++; if (r !== tr[i]) begin bad++; $display("FAIL dir%0d_remainder got=%h exp=%h", i, r, tr[i]); end
      total++; if (dz !== tdz[i]) begin bad++; $display("FAIL dir%0d_div_by_zero got=%b exp=%b", i, dz, tdz[i]); end
    end
    // Outputs hold between results.
    repeat (5) @(posedge clk);
    #1;
    total++; if (quotient !== tq[6]) begin bad++; $display("FAIL hold_quotient got=%h exp=%h", quotient, tq[6]); end
    total++; if (remainder !== tr[6]) begin bad++; $display("FAIL hold_remainder got=%h exp=%h", remainder, tr[6]); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL hold_result_valid got=%b exp=0", result_valid); end
  endtask

  task automatic test_random();
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic edz;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1, 2:    b = $signed($urandom_range(0, 30)) - 15;
        3:       b = $urandom_range(1, 255) << $urandom_range(0, 20);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      ref_div(a, b, eq, er, edz);
      run_op(a, b, q, r, dz, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      total++; if (q !== eq) begin bad++; $display("FAIL rnd%0d_quotient a=%h b=%h got=%h exp=%h", i, a, b, q, eq); end
      total++; if (r !== er) begin bad++; $display("FAIL rnd%0d_remainder a=%h b=%h got=%h exp=%h", i, a, b, r, er); end
      total++; if (dz !== edz) begin bad++; $display("FAIL rnd%0d_div_by_zero got=%b exp=%b", i, dz, edz); end
    end
  endtask

  // operands_valid stays high while the operands change every cycle: only the
  // pair present at an IDLE edge is taken, so the scoreboard expects pair 0
  // (accepted at edge 0) and pair LAT+1 (accepted the edge after the result).
  task automatic test_back_to_back();
    logic signed [W-1:0] pa [80];
    logic signed [W-1:0] pb [80];
    logic [2*W-1:0] exp_q [$];
    int             exp_edge [$];
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic edz;
    logic [2*W-1:0] exp_v;
    int seen;
    int guard;
    for (int i = 0; i < 80; i++) begin
      pa[i] = $urandom;
      pb[i] = $signed($urandom_range(1, 1000)) - 500;
      if (pb[i] == 0) pb[i] = 3;
    end
    ref_div(pa[0], pb[0], eq, er, edz);
    exp_q.push_back({eq, er});
    exp_edge.push_back(LAT);
    ref_div(pa[LAT + 1], pb[LAT + 1], eq, er, edz);
    exp_q.push_back({eq, er});
    exp_edge.push_back(2 * LAT + 1);
    guard = 0;
    @(negedge clk);
    while (!ready && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    A = pa[0];
    B = pb[0];
    operands_valid = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int e = 1; e < 80 && exp_q.size() != 0; e++) begin
      #1;
      A = pa[e];
      B = pb[e];
      @(posedge clk);
      #1;
      if (result_valid) begin
        seen++;
        exp_v = exp_q.pop_front();
        total++; if (e !== exp_edge[0]) begin bad++; $display("FAIL b2b%0d_edge got=%0d exp=%0d", seen, e, exp_edge[0]); end
        void'(exp_edge.pop_front());
        total++; if ({quotient, remainder} !== exp_v) begin bad++; $display("FAIL b2b%0d_result got=%h exp=%h", seen, {quotient, remainder}, exp_v); end
      end
    end
    operands_valid = 1'b0;
    total++; if (seen !== 2) begin bad++; $display("FAIL b2b_result_count got=%0d exp=2", seen); end
    repeat (LAT + 4) @(posedge clk);
  endtask

  task automatic test_reset_mid_iter();
    int lat;
    @(negedge clk);
    A = 1000;
    B = 7;
    operands_valid = 1'b1;
    @(posedge clk);
    #1 operands_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (quotient !== '0) begin bad++; $display("FAIL rst_mid_quotient got=%h exp=0", quotient); end
    total++; if (remainder !== '0) begin bad++; $display("FAIL rst_mid_remainder got=%h exp=0", remainder); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_result_valid got=%b exp=0", result_valid); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_mid_div_by_zero got=%b exp=0", div_by_zero); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", ready); end
    // Operands offered during reset must not be taken.
    A = 15;
    B = 4;
    operands_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      total++; if (dbg_state_o !== IDLE) begin bad++; $display("FAIL rst_hold_state got=%0d exp=IDLE", dbg_state_o); end
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 operands_valid = 1'b0;
    total++; if (dbg_state_o !== ITER) begin bad++; $display("FAIL rst_release_accept got=%0d exp=ITER", dbg_state_o); end
    lat = -1;
    for (int e = 1; e <= MAX_WAIT; e++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        lat = e;
        break;
      end
    end
    total++; if (lat !== LAT) begin bad++; $display("FAIL rst_after_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (quotient !== 32'd3) begin bad++; $display("FAIL rst_after_quotient got=%h exp=3", quotient); end
    total++; if (remainder !== 32'd3) begin bad++; $display("FAIL rst_after_remainder got=%h exp=3", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_after_div_by_zero got=%b exp=0", div_by_zero); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_iter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
